// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: serves loads and byte-lane
// stores from a word-addressed array after WAIT wait states, stalling the core.
module data_mem_responder #(
   parameter int ADDR_W = 12,
   parameter int WAIT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic [3:0]  mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_stall,
   output logic        mem_done,
   output logic        mem_err
);

   localparam int DEPTH = 1 << (ADDR_W - 2);
   localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   logic [31:0]       storage [DEPTH];
   state_t            state;
   logic [3:0]        cnt;
   logic              req;
   logic              req_err;
   logic              enter_resp;
   logic [ADDR_W-3:0] word_idx;
   logic [ADDR_W-3:0] wr_idx;
   logic [31:0]       wr_data;
   logic [3:0]        wr_lanes;
   logic              unused_addr;

   assign req         = mem_read | (|mem_write);
   assign req_err     = (|mem_addr[31:ADDR_W]) | (mem_read & (|mem_write));
   assign word_idx    = mem_addr[ADDR_W-1:2];
   assign unused_addr = ^mem_addr[1:0];
   assign mem_stall   = req && (state != ST_RESP);
   assign enter_resp  = req && (((state == ST_IDLE) && (WAIT == 0)) ||
                                ((state == ST_WAIT) && (cnt == 4'd0)));

   // Request sequencing; the store is captured on RESP entry and committed when RESP ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         mem_rdata <= 32'd0;
         mem_done  <= 1'b0;
         mem_err   <= 1'b0;
         wr_idx    <= '0;
         wr_data   <= 32'd0;
         wr_lanes  <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  if (WAIT > 0) begin
                     state <= ST_WAIT;
                     cnt   <= CNT_INIT;
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state <= ST_IDLE;
                  cnt   <= 4'd0;
               end else if (cnt == 4'd0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         mem_done <= enter_resp;
         mem_err  <= enter_resp & req_err;
         if (enter_resp) begin
            mem_rdata <= (mem_read && !req_err) ? storage[word_idx] : 32'd0;
            wr_lanes  <= req_err ? 4'd0 : mem_write;
            wr_idx    <= word_idx;
            wr_data   <= mem_wdata;
         end
      end
   end

   // Storage has no reset so its contents survive rst_n; a reset during RESP drops the store.
   always_ff @(posedge clk) begin
      if (state == ST_RESP) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_lanes[i]) storage[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances with WAIT = 1, 3 and 0,
// table-driven requests plus hand-written abort/reset/back-to-back sequences.
module tb_data_mem_responder;

   typedef struct {
      int          dut;
      logic        rd;
      logic [3:0]  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stalls;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        rd_s    [3];
   logic [3:0]  wr_s    [3];
   logic [31:0] addr_s  [3];
   logic [31:0] wdata_s [3];
   logic [31:0] rdata_s [3];
   logic        stall_s [3];
   logic        done_s  [3];
   logic        err_s   [3];

   int   compared;
   int   mismatched;
   exp_t sb [$];
   vec_t vecs [$];
   int   wait_of [3] = '{1, 3, 0};

   data_mem_responder #(.ADDR_W(12), .WAIT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
      .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]), .mem_rdata(rdata_s[0]),
      .mem_stall(stall_s[0]), .mem_done(done_s[0]), .mem_err(err_s[0]));

   data_mem_responder #(.ADDR_W(12), .WAIT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
      .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]), .mem_rdata(rdata_s[1]),
      .mem_stall(stall_s[1]), .mem_done(done_s[1]), .mem_err(err_s[1]));

   data_mem_responder #(.ADDR_W(12), .WAIT(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd_s[2]), .mem_write(wr_s[2]),
      .mem_addr(addr_s[2]), .mem_wdata(wdata_s[2]), .mem_rdata(rdata_s[2]),
      .mem_stall(stall_s[2]), .mem_done(done_s[2]), .mem_err(err_s[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic set_inputs(input int d, input logic rd, input logic [3:0] wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
      rd_s[d]    = rd;
      wr_s[d]    = wr;
      addr_s[d]  = addr;
      wdata_s[d] = wdata;
   endtask

   // Called just after a falling edge; returns just after the falling edge following RESP.
   task automatic apply_stimulus(input int d, input logic rd, input logic [3:0] wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      int   stalls;
      bit   seen;
      e.rdata  = exp_rdata;
      e.err    = exp_err;
      e.stalls = wait_of[d] + 1;
      sb.push_back(e);
      set_inputs(d, rd, wr, addr, wdata);
      stalls = 0;
      seen   = 0;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (done_s[d]) begin
            seen = 1;
            break;
         end
         if (stall_s[d]) stalls++;
         @(negedge clk);
         #1;
      end
      e = sb.pop_front();
      if (!seen) begin
         check_output("done_timeout", 32'd0, 32'd1);
      end else begin
         check_output("rdata", rdata_s[d], e.rdata);
         check_output("err", {31'd0, err_s[d]}, {31'd0, e.err});
         check_output("stall_cycles", stalls, e.stalls);
         check_output("stall_in_resp", {31'd0, stall_s[d]}, 32'd0);
      end
      @(negedge clk);
      #1;
      check_output("done_single_pulse", {31'd0, done_s[d]}, 32'd0);
      check_output("err_outside_resp", {31'd0, err_s[d]}, 32'd0);
   endtask

   task automatic add_vec(input int d, input logic rd, input logic [3:0] wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.dut = d; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      vecs.push_back(v);
   endtask

   initial begin
      bit any_done;
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      for (int d = 0; d < 3; d++) set_inputs(d, 1'b0, 4'd0, 32'd0, 32'd0);

      // Reset state with idle inputs, then a request held during reset.
      #12;
      for (int d = 0; d < 3; d++) begin
         check_output("reset_rdata", rdata_s[d], 32'd0);
         check_output("reset_done", {31'd0, done_s[d]}, 32'd0);
         check_output("reset_err", {31'd0, err_s[d]}, 32'd0);
         check_output("reset_stall", {31'd0, stall_s[d]}, 32'd0);
      end
      rd_s[0] = 1'b1;
      #1;
      check_output("reset_req_stall", {31'd0, stall_s[0]}, 32'd1);
      repeat (2) @(negedge clk);
      #1;
      check_output("reset_req_no_done", {31'd0, done_s[0]}, 32'd0);
      check_output("reset_req_stall_held", {31'd0, stall_s[0]}, 32'd1);
      rd_s[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // WAIT=1 table: full store/read, byte lanes, unaligned read, error cases.
      add_vec(0, 1'b0, 4'b1111, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0);
      add_vec(0, 1'b1, 4'b0000, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0);
      add_vec(0, 1'b0, 4'b1111, 32'h20,        32'h11223344, 32'h0,        1'b0);
      add_vec(0, 1'b0, 4'b0101, 32'h20,        32'hAABBCCDD, 32'h0,        1'b0);
      add_vec(0, 1'b1, 4'b0000, 32'h20,        32'h0,        32'h11BB33DD, 1'b0);
      add_vec(0, 1'b1, 4'b0000, 32'h23,        32'h0,        32'h11BB33DD, 1'b0);
      add_vec(0, 1'b1, 4'b0000, 32'h0000_1000, 32'h0,        32'h0,        1'b1);
      add_vec(0, 1'b1, 4'b0000, 32'h20,        32'h0,        32'h11BB33DD, 1'b0);
      add_vec(0, 1'b1, 4'b0001, 32'h20,        32'hFFFFFFFF, 32'h0,        1'b1);
      add_vec(0, 1'b1, 4'b0000, 32'h20,        32'h0,        32'h11BB33DD, 1'b0);
      add_vec(0, 1'b0, 4'b1010, 32'h10,        32'h55667788, 32'h0,        1'b0);
      add_vec(0, 1'b1, 4'b0000, 32'h10,        32'h0,        32'h55AD77EF, 1'b0);
      add_vec(0, 1'b0, 4'b1111, 32'hFFFF_0010, 32'h0,        32'h0,        1'b1);
      add_vec(0, 1'b1, 4'b0000, 32'h10,        32'h0,        32'h55AD77EF, 1'b0);
      add_vec(1, 1'b0, 4'b1111, 32'h40,        32'h12345678, 32'h0,        1'b0);
      add_vec(1, 1'b1, 4'b0000, 32'h40,        32'h0,        32'h12345678, 1'b0);
      foreach (vecs[i])
         apply_stimulus(vecs[i].dut, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                        vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      set_inputs(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_inputs(1, 1'b0, 4'd0, 32'd0, 32'd0);

      // WAIT=3: store dropped after one wait cycle must not complete or write.
      @(negedge clk);
      #1;
      set_inputs(1, 1'b0, 4'b1111, 32'h40, 32'hFFFFFFFF);
      @(negedge clk);
      #1;
      set_inputs(1, 1'b0, 4'd0, 32'd0, 32'd0);
      any_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (done_s[1]) any_done = 1;
      end
      check_output("abort_no_done", {31'd0, any_done}, 32'd0);
      apply_stimulus(1, 1'b1, 4'd0, 32'h40, 32'd0, 32'h12345678, 1'b0);
      set_inputs(1, 1'b0, 4'd0, 32'd0, 32'd0);

      // WAIT=3: reset asserted during WAIT discards the store and zeroes outputs.
      @(negedge clk);
      #1;
      set_inputs(1, 1'b0, 4'b1111, 32'h40, 32'h00000000);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("midreset_rdata", rdata_s[1], 32'd0);
      check_output("midreset_done", {31'd0, done_s[1]}, 32'd0);
      check_output("midreset_err", {31'd0, err_s[1]}, 32'd0);
      check_output("midreset_rdata_dut0", rdata_s[0], 32'd0);
      set_inputs(1, 1'b0, 4'd0, 32'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      apply_stimulus(1, 1'b1, 4'd0, 32'h40, 32'd0, 32'h12345678, 1'b0);
      set_inputs(1, 1'b0, 4'd0, 32'd0, 32'd0);

      // WAIT=0: fill ten consecutive words, then ten back-to-back reads.
      for (int i = 0; i < 10; i++)
         apply_stimulus(2, 1'b0, 4'b1111, 32'(4 * i), 32'hA000_0000 + 32'(i) * 32'h0101_0101,
                        32'd0, 1'b0);
      for (int i = 0; i < 10; i++)
         apply_stimulus(2, 1'b1, 4'd0, 32'(4 * i), 32'd0,
                        32'hA000_0000 + 32'(i) * 32'h0101_0101, 1'b0);
      set_inputs(2, 1'b0, 4'd0, 32'd0, 32'd0);
      check_output("scoreboard_empty", sb.size(), 32'd0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the single-cycle core's data port.
- Accepts the load/store strobes the control decoder produces: `mem_read`, plus the 4-bit byte-lane `mem_write`, together with the address and write data from the datapath.
- Serves each request from an internal word-addressed storage array after a programmable number of wait states, and stalls the core until the response cycle.
- Sits between the core's data-memory strobes and the storage array; it replaces the ideal zero-latency data memory.

## Interface
- `ADDR_W`, default 12: byte-address bits decoded. Storage holds 2^(ADDR_W-2) 32-bit words.
- `WAIT`, default 1: wait-state cycles per request, legal range 0..15.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mem_read`  in  1  load request.
- `mem_write`  in  4  store byte strobes; bit i writes byte lane i (bits 8i+7:8i).
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  store data, lane-aligned.
- `mem_rdata`  out  32  load data, registered.
- `mem_stall`  out  1  core must hold PC and request stable while high.
- `mem_done`  out  1  single-cycle pulse marking the response cycle.
- `mem_err`  out  1  response flag, valid when `mem_done` is high.

## Operation
- A request is present when `mem_read`=1 or `mem_write`≠0.
- Word index is `mem_addr[ADDR_W-1:2]`. `mem_addr[1:0]` is ignored.
- A request is an error when either:
  - any of `mem_addr[31:ADDR_W]` is nonzero, or
  - `mem_read`=1 and `mem_write`≠0 at the same time.
- FSM states:
  - IDLE: request present → go to WAIT with cnt=WAIT−1 if WAIT>0, otherwise go to RESP. No request → stay in IDLE.
  - WAIT: request still present → if cnt=0 go to RESP, else cnt−1. Request dropped → abort to IDLE with no write and no `mem_done`.
  - RESP: go to IDLE unconditionally.
- `mem_stall` is combinational: 1 when a request is present and state≠RESP, 0 otherwise.
- The transition into RESP does two things:
  - Loads `mem_rdata`: the array word for a legal read, 0 for an error or a store.
  - Registers the error flag.
- On the clock edge that leaves RESP, a legal store writes only the enabled byte lanes. Other lanes keep their value. An errored store writes nothing.
- `mem_done` is 1 in RESP only. `mem_err` equals the registered flag in RESP and is 0 elsewhere.
- `mem_rdata` holds its value until the next entry into RESP.
- The storage array has no reset. Its contents survive `rst_n` assertion.
- Any strobe pattern is legal, including non-contiguous ones such as 4'b0101.

## Timing
- Reset values: state=IDLE, cnt=0, `mem_rdata`=0, `mem_done`=0, `mem_err`=0. `mem_stall` follows the request inputs combinationally, because state is IDLE.
- Per-request cycle budget: request cycle, then WAIT wait cycles, then RESP. That is WAIT+2 cycles in total, with `mem_stall` high for WAIT+1 of them.
- With WAIT=0: one stall cycle, then RESP.
- The core advances on the edge that ends RESP. A new request seen in IDLE on the next cycle starts a new sequence; there is no bubble beyond IDLE.
- A request still asserted in RESP is not re-accepted in RESP. It is treated as new only once the state is back in IDLE.
- Read-after-write to the same word in back-to-back requests returns the new data. The write commits before the next request's RESP entry.
- `rst_n` low in any state: outputs return to their reset values asynchronously. An in-flight store is discarded.

## Test plan
- Reset with inputs idle → `mem_rdata`=0, `mem_done`=0, `mem_err`=0, `mem_stall`=0. Assert a request during reset → `mem_stall`=1 and state stays in IDLE.
- WAIT=1: store 4'b1111 of 0xDEADBEEF to 0x10, then read 0x10 → each request shows stall high for 2 cycles and `mem_done` in the 3rd; the read returns 0xDEADBEEF.
- Byte lanes: over 0x11223344 at 0x20, store 4'b0101 with data 0xAABBCCDD, then read → 0x11BB33DD. A read of 0x23 returns the same word.
- Errors:
  - Read of 0x0000_1000 (ADDR_W=12) → `mem_err`=1 and `mem_rdata`=0 in RESP.
  - `mem_read`=1 together with `mem_write`=4'b0001 → `mem_err`=1, and the target word is unchanged on re-read.
- Abort and reset mid-operation: WAIT=3, drop a store after 1 wait cycle → no `mem_done` and word unchanged. Assert `rst_n` during WAIT → immediate IDLE, outputs zero, array contents intact.
- WAIT=0, ten back-to-back reads of consecutive words → each read takes 2 cycles (stall 1, `mem_done` 1), with correct data and no lost or duplicated `mem_done` pulses.
